jpeg_block_sequencer: RTL
=========================

// Module: jpeg_block_sequencer
// PURPOSE
//  Per-8x8-block control FSM driving the HW_JPEGenc strobe/select inputs in order:
//  load -> DCT -> DCT capture -> 8 quantize rows -> zigzag -> Huffman -> done.
//  Upstream offers one block per valid/ready handshake; the sequencer tracks Huffman completion.
// PARAMETERS
//  DCT_LATENCY    4     cycles from dct_enable to valid DCT_2D output (>=1)
//  QUANT_LATENCY  2     cycles from matrix_row change to valid Quantize row (>=0)
//  HUFF_TIMEOUT   256   max cycles after Huffman_start to wait for huff_active rise (>=2)
// PORTS
//  clock                input   1  system clock, rising edge
//  reset_n              input   1  asynchronous active-low reset
//  blk_valid            input   1  upstream block (pix_data) stable and offered
//  blk_is_luma          input   1  component type of offered block, sampled at accept
//  blk_ready            output  1  sequencer idle; accept when blk_valid&blk_ready&!abort
//  abort                input   1  sync abort: return to IDLE, no blk_done
//  huff_active          input   1  Huffman controller busy (Huffmanenc_active)
//  input_enable         output  1  1-cycle pulse: capture 64-pix block
//  dct_enable           output  1  1-cycle pulse: start DCT_2D
//  dct_end_enable       output  1  1-cycle pulse: capture DCT result buffer
//  matrix_row           output  8  quantize/zigzag row select 0..7
//  zigzag_input_enable  output  1  1-cycle pulse per row: write Quantize row into zigzag buffer
//  zigag_enable         output  1  1-cycle pulse: perform zigzag reorder
//  Huffman_start        output  1  1-cycle pulse: start Huffman encode
//  is_luminance         output  1  blk_is_luma latched at accept, held until next accept
//  blk_done             output  1  1-cycle pulse: block fully encoded (or timed out)
//  huff_timeout         output  1  sticky error; cleared at next accept
//  busy                 output  1  state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; all pulses, matrix_row, is_luminance, huff_timeout = 0; blk_ready=1.
//  All outputs registered except blk_ready/busy (state decode). Accept in cycle 0:
//   LOAD     c1                input_enable=1
//   DCT      c2                dct_enable=1
//   DCT_WAIT c3..c(2+DCT_LATENCY), down-counter
//   DCT_END  c(3+DCT_LATENCY)  dct_end_enable=1
//   QUANT    rows r=0..7, each QUANT_LATENCY+1 cycles with matrix_row=r;
//            zigzag_input_enable=1 on last cycle of each row window
//   ZIGZAG   next cycle        zigag_enable=1, matrix_row back to 0
//   HSTART   next cycle        Huffman_start=1
//   HWAIT    wait huff_active=1 (seen flag), then huff_active=0 -> DONE
//   DONE     blk_done=1 for 1 cycle -> IDLE
//  Defaults: dct_end_enable c7; rows c8..c31; zigzag_input_enable c10,13,..,31;
//   zigag_enable c32; Huffman_start c33.
//  HWAIT timeout: huff_active never high within HUFF_TIMEOUT cycles after Huffman_start
//   -> huff_timeout=1, DONE (blk_done still pulses).
//  huff_active already high in cycle of Huffman_start counts as seen.
//  abort: any non-IDLE state -> IDLE next cycle, pulses 0, matrix_row 0, no blk_done;
//   abort & blk_valid in IDLE -> not accepted.
//  blk_valid ignored while busy; no queuing. Back-to-back: accept possible cycle after DONE.
//  reset_n low mid-block -> immediate IDLE, all outputs to reset values.
//  Pulses never overlap; at most one of the 1-cycle strobes high per cycle.
// STRUCTURE
//  jpeg_seq_pkg: state enum (IDLE,LOAD,DCT,DCT_WAIT,DCT_END,QUANT,ZIGZAG,HSTART,HWAIT,DONE),
//   NUM_ROWS=8, default latency constants, counter width function.
//  Sub-module seq_cycle_counter: loadable down-counter with zero flag, shared by
//   DCT_WAIT, per-row window and HWAIT timeout.
// TESTING
//  1 default params, blk_valid=1 luma, huff_active high c35..c60 -> strobes exactly at
//    c1,c2,c7,c10..c31 step 3,c32,c33; blk_done c62; is_luminance=1.
//  2 abort at c15 (row 2) -> IDLE c16, no further strobes, no blk_done; next block runs clean.
//  3 huff_active held 0, HUFF_TIMEOUT=16 -> huff_timeout=1, blk_done once; cleared on next accept.
//  4 two chroma blocks back-to-back, blk_valid held high -> second accept cycle after blk_done.
//  5 QUANT_LATENCY=0, DCT_LATENCY=1 -> dct_end_enable c4, zigzag_input_enable every cycle c5..c12.
//  6 reset_n pulsed low during HWAIT -> all outputs 0, blk_ready=1, huff_timeout=0.

Source files
------------

// File: rtl/jpeg_block_sequencer_pkg.sv
// jpeg_seq_pkg: shared states, constants and sizing helpers for the block sequencer
package jpeg_seq_pkg;
    typedef enum logic [3:0] {
        IDLE, LOAD, DCT, DCT_WAIT, DCT_END, QUANT, ZIGZAG, HSTART, HWAIT, DONE
    } seq_state_t;
    localparam int NUM_ROWS          = 8;
    localparam int DEF_DCT_LATENCY   = 4;
    localparam int DEF_QUANT_LATENCY = 2;
    localparam int DEF_HUFF_TIMEOUT  = 256;
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        return m > c ? m : c;
    endfunction
    function automatic int cnt_width(input int max_value);
        int w;
        w = 1;
        while ((1 << w) <= max_value) w = w + 1;
        return w;
    endfunction
endpackage

// File: rtl/jpeg_block_sequencer_if.sv
// jpeg_block_sequencer_if: upstream handshake, Huffman status and encoder strobe bundle
interface jpeg_block_sequencer_if;
    logic       blk_valid;
    logic       blk_is_luma;
    logic       blk_ready;
    logic       abort;
    logic       huff_active;
    logic       input_enable;
    logic       dct_enable;
    logic       dct_end_enable;
    logic [7:0] matrix_row;
    logic       zigzag_input_enable;
    logic       zigag_enable;
    logic       Huffman_start;
    logic       is_luminance;
    logic       blk_done;
    logic       huff_timeout;
    logic       busy;
    modport master (
        output blk_valid, blk_is_luma, abort, huff_active,
        input  blk_ready, input_enable, dct_enable, dct_end_enable, matrix_row,
               zigzag_input_enable, zigag_enable, Huffman_start, is_luminance,
               blk_done, huff_timeout, busy
    );
    modport slave (
        input  blk_valid, blk_is_luma, abort, huff_active,
        output blk_ready, input_enable, dct_enable, dct_end_enable, matrix_row,
               zigzag_input_enable, zigag_enable, Huffman_start, is_luminance,
               blk_done, huff_timeout, busy
    );
endinterface

// File: rtl/jpeg_block_sequencer_counter.sv
// seq_cycle_counter: loadable saturating down-counter with zero flag
module seq_cycle_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             zero
);
    assign zero = count == '0;
    // load wins; otherwise count down and hold at zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else if (load) count <= load_value;
        else if (!zero) count <= count - 1'b1;
    end
endmodule

// File: rtl/jpeg_block_sequencer.sv
// jpeg_block_sequencer: per-8x8-block strobe sequencer for the HW_JPEGenc datapath
module jpeg_block_sequencer
    import jpeg_seq_pkg::*;
#(
    parameter int DCT_LATENCY   = DEF_DCT_LATENCY,
    parameter int QUANT_LATENCY = DEF_QUANT_LATENCY,
    parameter int HUFF_TIMEOUT  = DEF_HUFF_TIMEOUT
) (
    input logic                   clock,
    input logic                   reset_n,
    jpeg_block_sequencer_if.slave bus
);
    localparam int CW = cnt_width(max3(DCT_LATENCY - 1, QUANT_LATENCY, HUFF_TIMEOUT - 1));
    seq_state_t    state, state_next;
    logic [CW-1:0] count, load_value;
    logic          zero, load, seen, accept, timed_out, row_end, zie_next;
    assign accept        = state == IDLE && bus.blk_valid && !bus.abort;
    assign row_end       = state == QUANT && zero;
    assign timed_out     = state == HWAIT && !seen && !bus.huff_active && zero && !bus.abort;
    assign bus.blk_ready = state == IDLE;
    assign bus.busy      = state != IDLE;
    seq_cycle_counter #(.WIDTH(CW)) u_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .zero       (zero)
    );
    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_next;
    end
    // next state, counter reload and the look-ahead for the per-row zigzag write strobe
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     state_next = accept ? LOAD : IDLE;
            LOAD:     state_next = DCT;
            DCT:      state_next = DCT_WAIT;
            DCT_WAIT: state_next = zero ? DCT_END : DCT_WAIT;
            DCT_END:  state_next = QUANT;
            QUANT:    state_next = (row_end && bus.matrix_row == 8'(NUM_ROWS - 1)) ? ZIGZAG : QUANT;
            ZIGZAG:   state_next = HSTART;
            HSTART:   state_next = HWAIT;
            HWAIT:    state_next = (!bus.huff_active && (seen || zero)) ? DONE : HWAIT;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (bus.abort) state_next = IDLE;
        load       = state == DCT || state == HSTART || (state_next == QUANT && (state != QUANT || zero));
        load_value = state == DCT ? CW'(DCT_LATENCY - 1) : state == HSTART ? CW'(HUFF_TIMEOUT - 1) : CW'(QUANT_LATENCY);
        zie_next   = state_next == QUANT && (load ? QUANT_LATENCY == 0 : count == CW'(1));
    end
    // registered strobes decoded from the upcoming state so they line up with it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.input_enable        <= 1'b0;
            bus.dct_enable          <= 1'b0;
            bus.dct_end_enable      <= 1'b0;
            bus.zigzag_input_enable <= 1'b0;
            bus.zigag_enable        <= 1'b0;
            bus.Huffman_start       <= 1'b0;
            bus.blk_done            <= 1'b0;
            bus.matrix_row          <= 8'd0;
            bus.is_luminance        <= 1'b0;
            bus.huff_timeout        <= 1'b0;
            seen                    <= 1'b0;
        end else begin
            bus.input_enable        <= state_next == LOAD;
            bus.dct_enable          <= state_next == DCT;
            bus.dct_end_enable      <= state_next == DCT_END;
            bus.zigzag_input_enable <= zie_next;
            bus.zigag_enable        <= state_next == ZIGZAG;
            bus.Huffman_start       <= state_next == HSTART;
            bus.blk_done            <= state_next == DONE;
            bus.matrix_row          <= state_next != QUANT ? 8'd0 : row_end ? bus.matrix_row + 8'd1 : bus.matrix_row;
            bus.is_luminance        <= accept ? bus.blk_is_luma : bus.is_luminance;
            bus.huff_timeout        <= accept ? 1'b0 : (bus.huff_timeout || timed_out);
            seen                    <= state == HSTART ? bus.huff_active : (state == HWAIT && (seen || bus.huff_active));
        end
    end
endmodule
